// File: rtl/mips_run_monitor.sv
// ============================================================================
// mips_run_monitor : run controller for the multi-cycle MIPS core
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_run_monitor #(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 72,
  parameter int CNT_W      = 32,
  parameter int PC_W       = 32,
  parameter int LOOP_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             fetch_valid_i,
  input  logic [PC_W-1:0]  fetch_pc_i,
  output logic             cpu_rst_n_o,
  output logic             cpu_en_o,
  output logic             running_o,
  output logic             done_o,
  output logic [1:0]       done_cause_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam int RC_W = $clog2(RST_CYCLES) + 1;

  localparam logic [1:0]       C_CAUSE_NONE    = 2'b00;
  localparam logic [1:0]       C_CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0]       C_CAUSE_HALT    = 2'b10;
  localparam logic [1:0]       C_CAUSE_ABORT   = 2'b11;
  localparam logic [RC_W-1:0]  C_RST_LAST      = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CYC_LAST      = CNT_W'(MAX_CYCLES - 1);
  localparam logic [7:0]       C_LOOP_LIMIT    = 8'(LOOP_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic [1:0]       cause_q, cause_d;
  logic [7:0]       loop_q, loop_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic             pc_vld_q, pc_vld_d;
  logic             cpu_rst_n_q, cpu_rst_n_d;
  logic             cpu_en_q, cpu_en_d;
  logic             running_q, running_d;
  logic             done_q, done_d;

  logic             w_hit;
  logic [7:0]       w_loop_inc;
  logic             w_halt;

  assign w_hit      = pc_vld_q && (fetch_pc_i == last_pc_q);
  assign w_loop_inc = loop_q + 8'd1;
  assign w_halt     = fetch_valid_i && w_hit && (w_loop_inc == C_LOOP_LIMIT);

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cycle_d   = cycle_q;
    instr_d   = instr_q;
    cause_d   = cause_q;
    loop_d    = loop_q;
    last_pc_d = last_pc_q;
    pc_vld_d  = pc_vld_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d   = S_RESET;
          rst_cnt_d = '0;
          cycle_d   = '0;
          instr_d   = '0;
          cause_d   = C_CAUSE_NONE;
          loop_d    = '0;
          pc_vld_d  = 1'b0;
        end
      end
      S_RESET: begin
        if (rst_cnt_q == C_RST_LAST) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      S_RUN: begin
        cycle_d = cycle_q + CNT_W'(1);
        if (fetch_valid_i) begin
          if (instr_q != '1) begin
            instr_d = instr_q + CNT_W'(1);
          end
          loop_d    = w_hit ? w_loop_inc : 8'd0;
          last_pc_d = fetch_pc_i;
          pc_vld_d  = 1'b1;
        end
        // Exit priority: abort over halt over timeout.
        if (abort_i) begin
          state_d = S_DONE;
          cause_d = C_CAUSE_ABORT;
        end else if (w_halt) begin
          state_d = S_DONE;
          cause_d = C_CAUSE_HALT;
        end else if (cycle_q == C_CYC_LAST) begin
          state_d = S_DONE;
          cause_d = C_CAUSE_TIMEOUT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cpu_rst_n_d = (state_d == S_RUN) || (state_d == S_DONE);
    cpu_en_d    = (state_d == S_RESET) || (state_d == S_RUN);
    running_d   = (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      cycle_q     <= '0;
      instr_q     <= '0;
      cause_q     <= C_CAUSE_NONE;
      loop_q      <= '0;
      last_pc_q   <= '0;
      pc_vld_q    <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      cpu_en_q    <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cycle_q     <= cycle_d;
      instr_q     <= instr_d;
      cause_q     <= cause_d;
      loop_q      <= loop_d;
      last_pc_q   <= last_pc_d;
      pc_vld_q    <= pc_vld_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      cpu_en_q    <= cpu_en_d;
      running_q   <= running_d;
      done_q      <= done_d;
    end
  end

  assign cpu_rst_n_o  = cpu_rst_n_q;
  assign cpu_en_o     = cpu_en_q;
  assign running_o    = running_q;
  assign done_o       = done_q;
  assign done_cause_o = cause_q;
  assign cycle_cnt_o  = cycle_q;
  assign instr_cnt_o  = instr_q;

endmodule

`default_nettype wire

// File: doc/mips_run_monitor.md
# mips_run_monitor

Parametrised run controller for the multi-cycle MIPS core. It sequences the core's reset, gates its clock enable and counts cycles and retired fetches. It stops the run on a cycle budget, on a self-loop halt (repeated fetch of the same PC), or on an external abort, and latches the cause. It sits between the top-level clock/reset and the CPU instance, replacing a fixed free-running cycle counter with a synthesizable, reusable controller.

## Interface
- RST_CYCLES, 2: cycles `cpu_rst_n` is held low per run (≥1)
- MAX_CYCLES, 72: RUN-cycle budget before timeout (≥1, < 2^CNT_W)
- CNT_W, 32: width of cycle and instruction counters
- PC_W, 32: width of fetch PC
- LOOP_LIMIT, 8: consecutive same-PC refetches that declare halt (≥1, < 2^8)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run; honoured in IDLE and DONE only
- abort  in  1  force end of run; honoured in RUN only
- fetch_valid  in  1  CPU fetch strobe, one cycle per instruction fetch
- fetch_pc  in  PC_W  PC of the fetch, valid with `fetch_valid`
- cpu_rst_n  out  1  active-low reset to CPU
- cpu_en  out  1  clock enable to CPU
- running  out  1  high in RUN
- done  out  1  high in DONE
- done_cause  out  2  00 none, 01 timeout, 10 self-loop halt, 11 abort
- cycle_cnt  out  CNT_W  RUN cycles elapsed
- instr_cnt  out  CNT_W  fetches counted in RUN, saturating

## Operation
- FSM states: IDLE, RESET, RUN, DONE. All outputs are registered.
- IDLE: `cpu_rst_n`=0, `cpu_en`=0. On `start`: go to RESET; clear `cycle_cnt`, `instr_cnt`, `done_cause`, loop state, and the reset counter.
- RESET: `cpu_rst_n`=0, `cpu_en`=1. After exactly RST_CYCLES cycles in RESET, go to RUN. `start` and `abort` are ignored.
- RUN: `cpu_rst_n`=1, `cpu_en`=1, `running`=1.
  - `cycle_cnt` increments every cycle.
  - `instr_cnt` increments on each `fetch_valid` and saturates at all-ones.
- Loop detect (RUN only):
  - An 8-bit `loop_cnt`, a `last_pc` register and a `pc_vld` flag.
  - On a fetch: if `pc_vld` and `fetch_pc`==`last_pc`, then `loop_cnt`+1; otherwise `loop_cnt`=0.
  - Every fetch sets `last_pc`=`fetch_pc` and `pc_vld`=1.
  - `pc_vld` is cleared on entry to RESET.
- Exit from RUN, evaluated each cycle. Priority is abort > halt > timeout.
  - `abort` → DONE, cause 11.
  - A fetch that makes `loop_cnt` reach LOOP_LIMIT → DONE, cause 10.
  - `cycle_cnt`==MAX_CYCLES−1 (the increment reaches MAX_CYCLES) → DONE, cause 01.
  - Counter updates of the exiting cycle still occur.
- DONE: `done`=1, `cpu_rst_n`=1, `cpu_en`=0. The CPU is frozen for inspection and all counters and the cause hold. `start` → RESET (new run, counters cleared). `abort` is ignored.
- `start` in RESET or RUN is ignored. `fetch_valid` outside RUN is ignored.

## Timing
- Reset values (while `rst`=1, asynchronously): state IDLE; `cpu_rst_n`=0, `cpu_en`=0, `running`=0, `done`=0, `done_cause`=00, `cycle_cnt`=0, `instr_cnt`=0, `loop_cnt`=0, `pc_vld`=0.
- `rst` asserted mid-run aborts without recording a cause. There is no DONE pulse.
- `start` sampled at edge E0 → RESET visible after E0.
- RUN is visible after E0+RST_CYCLES, with `cpu_rst_n` rising at the same edge.
- Timeout: DONE and `cycle_cnt`=MAX_CYCLES appear at the same edge, MAX_CYCLES edges after RUN entry.
- Abort or halt: DONE is visible one edge after the triggering cycle.
- `done` and `running` are never both high. `cpu_rst_n`=0 implies `running`=0.

## Test plan
- `rst` pulse, then idle 5 cycles → all outputs at reset values; `cpu_rst_n`=0, `cpu_en`=0.
- Defaults, `start` pulse, fetch every 4 cycles with incrementing PCs → `cpu_rst_n` low 2 cycles. DONE after 72 RUN cycles, `done_cause`=01, `cycle_cnt`=72, `instr_cnt`=18.
- Fetch PCs 0x0, 0x4, then 0x8 repeated every 4 cycles → halt on the 9th fetch of 0x8 (`loop_cnt`=8). `done_cause`=10, `instr_cnt`=11, `cycle_cnt` < 72.
- `abort` in the same cycle as the halt-completing fetch, at `cycle_cnt`=71 → `done_cause`=11 (priority). Counters include that cycle.
- `start` while in RUN → ignored. In DONE, `start` → counters zero, RESET for 2 cycles, new run completes with correct cause.
- `rst` asserted mid-RUN, asynchronously between edges → outputs return to reset values immediately. A subsequent `start` runs cleanly.
